pipe_control: RTL and testbench

- Pipelined successor to the single-cycle LEGv8 control unit, for the 5-stage CPU (IF/ID/EX/MEM/WB).
- Decodes the 32-bit instruction held in the IF/ID register into the same control bundle the single-cycle CPU uses.
- Carries that bundle through its own ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards: issues a stall and injects a bubble. Accepts a flush for taken branches.
- Keeps a saturating stall-cycle counter for performance tests.

---
 rtl/pipe_control.sv | 253 +++++++++++++++++++++++++
 tb/tb_pipe_control.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
`default_nettype none
// ============================================================================
// Module   : pipe_control
// Brief    : LEGv8 5-stage pipeline control. Decodes ID, carries controls
//            through EX/MEM/WB, and detects load-use hazards (stall + bubble).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_control #(
    parameter int ALUOP_W  = 3,
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        id_instr,
    input  logic               id_valid,
    input  logic               flush,
    output logic               stall,
    output logic               ex_valid,
    output logic               ex_immediate,
    output logic               ex_reg2Loc,
    output logic               ex_setPCReg,
    output logic               ex_link,
    output logic               ex_uncondBranch,
    output logic               ex_cbBranch,
    output logic               ex_cbzBranch,
    output logic               ex_memRead,
    output logic               ex_memToReg,
    output logic               ex_memWrite,
    output logic               ex_ALUSrc,
    output logic               ex_regWrite,
    output logic               ex_setFlags,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic [REG_W-1:0]   ex_rd,
    output logic [REG_W-1:0]   ex_rn,
    output logic [REG_W-1:0]   ex_rm,
    output logic               mem_valid,
    output logic               mem_memRead,
    output logic               mem_memWrite,
    output logic               mem_memToReg,
    output logic               mem_regWrite,
    output logic [REG_W-1:0]   mem_rd,
    output logic               wb_valid,
    output logic               wb_memToReg,
    output logic               wb_regWrite,
    output logic [REG_W-1:0]   wb_rd,
    output logic [CNT_W-1:0]   stall_count
);

    typedef struct packed {
        logic               immediate;
        logic               reg2Loc;
        logic               setPCReg;
        logic               link;
        logic               uncondBranch;
        logic               cbBranch;
        logic               cbzBranch;
        logic               memRead;
        logic               memToReg;
        logic               memWrite;
        logic               ALUSrc;
        logic               regWrite;
        logic               setFlags;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    localparam logic [ALUOP_W-1:0] c_alu_add  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] c_alu_sub  = ALUOP_W'(3);
    localparam logic [REG_W-1:0]   c_zero_reg = REG_W'(ZERO_REG);

    logic [10:0]      w_op;
    logic [REG_W-1:0] w_rd;
    logic [REG_W-1:0] w_rn;
    logic [REG_W-1:0] w_rm;
    ctrl_t            w_ctrl;
    logic             w_use_rn;
    logic             w_use_rm;
    logic             w_use_rt;
    logic             w_hazard;
    logic             w_stall;
    logic             w_bubble;
    logic             w_unused_imm;

    ctrl_t            r_ex_ctrl;
    logic             r_ex_valid;
    logic [REG_W-1:0] r_ex_rd;
    logic [REG_W-1:0] r_ex_rn;
    logic [REG_W-1:0] r_ex_rm;
    logic             r_mem_valid;
    logic             r_mem_memRead;
    logic             r_mem_memWrite;
    logic             r_mem_memToReg;
    logic             r_mem_regWrite;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_wb_valid;
    logic             r_wb_memToReg;
    logic             r_wb_regWrite;
    logic [REG_W-1:0] r_wb_rd;
    logic [CNT_W-1:0] r_stall_count;

    assign w_op         = id_instr[31:21];
    assign w_rd         = id_instr[REG_W-1:0];
    assign w_rn         = id_instr[5 +: REG_W];
    assign w_rm         = id_instr[16 +: REG_W];
    assign w_unused_imm = ^id_instr[15:10];

    always_comb begin
        w_ctrl   = '0;
        w_use_rn = 1'b0;
        w_use_rm = 1'b0;
        w_use_rt = 1'b0;
        if (w_op[10:1] == 10'b1001000100) begin                 // ADDI
            w_ctrl.immediate = 1'b1;
            w_ctrl.aluop     = c_alu_add;
            w_ctrl.ALUSrc    = 1'b1;
            w_ctrl.regWrite  = 1'b1;
            w_use_rn         = 1'b1;
        end else if (w_op == 11'b10101011000) begin             // ADDS
            w_ctrl.aluop     = c_alu_add;
            w_ctrl.regWrite  = 1'b1;
            w_ctrl.setFlags  = 1'b1;
            w_use_rn         = 1'b1;
            w_use_rm         = 1'b1;
        end else if (w_op == 11'b11101011000) begin             // SUBS
            w_ctrl.aluop     = c_alu_sub;
            w_ctrl.regWrite  = 1'b1;
            w_ctrl.setFlags  = 1'b1;
            w_use_rn         = 1'b1;
            w_use_rm         = 1'b1;
        end else if (w_op[10:5] == 6'b000101) begin             // B
            w_ctrl.uncondBranch = 1'b1;
        end else if (w_op[10:5] == 6'b100101) begin             // BL
            w_ctrl.link         = 1'b1;
            w_ctrl.uncondBranch = 1'b1;
            w_ctrl.regWrite     = 1'b1;
        end else if (w_op[10:3] == 8'b01010100) begin           // B.cond
            w_ctrl.cbBranch = 1'b1;
        end else if (w_op[10:3] == 8'b10110100) begin           // CBZ
            w_ctrl.reg2Loc   = 1'b1;
            w_ctrl.cbzBranch = 1'b1;
            w_use_rt         = 1'b1;
        end else if (w_op == 11'b11010110000) begin             // BR
            w_ctrl.reg2Loc      = 1'b1;
            w_ctrl.setPCReg     = 1'b1;
            w_ctrl.uncondBranch = 1'b1;
            w_use_rn            = 1'b1;
        end else if (w_op == 11'b11111000010) begin             // LDUR
            w_ctrl.memRead  = 1'b1;
            w_ctrl.memToReg = 1'b1;
            w_ctrl.aluop    = c_alu_add;
            w_ctrl.ALUSrc   = 1'b1;
            w_ctrl.regWrite = 1'b1;
            w_use_rn        = 1'b1;
        end else if (w_op == 11'b11111000000) begin             // STUR
            w_ctrl.reg2Loc  = 1'b1;
            w_ctrl.aluop    = c_alu_add;
            w_ctrl.ALUSrc   = 1'b1;
            w_ctrl.memWrite = 1'b1;
            w_use_rn        = 1'b1;
            w_use_rt        = 1'b1;
        end
    end

    // Stores and CBZ read their second operand from the Rt (Rd) field.
    assign w_hazard = id_valid & r_ex_valid & r_ex_ctrl.memRead & (r_ex_rd != c_zero_reg) &
                      ((w_use_rn & (w_rn == r_ex_rd)) |
                       (w_use_rm & (w_rm == r_ex_rd)) |
                       (w_use_rt & (w_rd == r_ex_rd)));
    assign w_stall  = w_hazard & ~flush & ~reset;
    assign w_bubble = flush | w_stall | ~id_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_ctrl      <= '0;
            r_ex_valid     <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_rn        <= '0;
            r_ex_rm        <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_memRead  <= 1'b0;
            r_mem_memWrite <= 1'b0;
            r_mem_memToReg <= 1'b0;
            r_mem_regWrite <= 1'b0;
            r_mem_rd       <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_memToReg  <= 1'b0;
            r_wb_regWrite  <= 1'b0;
            r_wb_rd        <= '0;
            r_stall_count  <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_ctrl  <= '0;
                r_ex_valid <= 1'b0;
                r_ex_rd    <= '0;
                r_ex_rn    <= '0;
                r_ex_rm    <= '0;
            end else begin
                r_ex_ctrl  <= w_ctrl;
                r_ex_valid <= 1'b1;
                r_ex_rd    <= w_rd;
                r_ex_rn    <= w_rn;
                r_ex_rm    <= w_rm;
            end
            r_mem_valid    <= r_ex_valid;
            r_mem_memRead  <= r_ex_ctrl.memRead;
            r_mem_memWrite <= r_ex_ctrl.memWrite;
            r_mem_memToReg <= r_ex_ctrl.memToReg;
            r_mem_regWrite <= r_ex_ctrl.regWrite;
            r_mem_rd       <= r_ex_rd;
            r_wb_valid     <= r_mem_valid;
            r_wb_memToReg  <= r_mem_memToReg;
            r_wb_regWrite  <= r_mem_regWrite;
            r_wb_rd        <= r_mem_rd;
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign stall           = w_stall;
    assign ex_valid        = r_ex_valid;
    assign ex_immediate    = r_ex_ctrl.immediate;
    assign ex_reg2Loc      = r_ex_ctrl.reg2Loc;
    assign ex_setPCReg     = r_ex_ctrl.setPCReg;
    assign ex_link         = r_ex_ctrl.link;
    assign ex_uncondBranch = r_ex_ctrl.uncondBranch;
    assign ex_cbBranch     = r_ex_ctrl.cbBranch;
    assign ex_cbzBranch    = r_ex_ctrl.cbzBranch;
    assign ex_memRead      = r_ex_ctrl.memRead;
    assign ex_memToReg     = r_ex_ctrl.memToReg;
    assign ex_memWrite     = r_ex_ctrl.memWrite;
    assign ex_ALUSrc       = r_ex_ctrl.ALUSrc;
    assign ex_regWrite     = r_ex_ctrl.regWrite;
    assign ex_setFlags     = r_ex_ctrl.setFlags;
    assign ex_ALUOp        = r_ex_ctrl.aluop;
    assign ex_rd           = r_ex_rd;
    assign ex_rn           = r_ex_rn;
    assign ex_rm           = r_ex_rm;
    assign mem_valid       = r_mem_valid;
    assign mem_memRead     = r_mem_memRead;
    assign mem_memWrite    = r_mem_memWrite;
    assign mem_memToReg    = r_mem_memToReg;
    assign mem_regWrite    = r_mem_regWrite;
    assign mem_rd          = r_mem_rd;
    assign wb_valid        = r_wb_valid;
    assign wb_memToReg     = r_wb_memToReg;
    assign wb_regWrite     = r_wb_regWrite;
    assign wb_rd           = r_wb_rd;
    assign stall_count     = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_control
// Brief    : Self-checking bench for pipe_control (table, directed, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_control;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             flush;
    logic             stall;
    logic             ex_valid, ex_immediate, ex_reg2Loc, ex_setPCReg, ex_link;
    logic             ex_uncondBranch, ex_cbBranch, ex_cbzBranch, ex_memRead;
    logic             ex_memToReg, ex_memWrite, ex_ALUSrc, ex_regWrite, ex_setFlags;
    logic [2:0]       ex_ALUOp;
    logic [4:0]       ex_rd, ex_rn, ex_rm;
    logic             mem_valid, mem_memRead, mem_memWrite, mem_memToReg, mem_regWrite;
    logic [4:0]       mem_rd;
    logic             wb_valid, wb_memToReg, wb_regWrite;
    logic [4:0]       wb_rd;
    logic [CNT_W-1:0] stall_count;

    always #5 clk = ~clk;

    pipe_control #(.ALUOP_W(3), .REG_W(5), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_immediate(ex_immediate),
        .ex_reg2Loc(ex_reg2Loc), .ex_setPCReg(ex_setPCReg), .ex_link(ex_link),
        .ex_uncondBranch(ex_uncondBranch), .ex_cbBranch(ex_cbBranch),
        .ex_cbzBranch(ex_cbzBranch), .ex_memRead(ex_memRead), .ex_memToReg(ex_memToReg),
        .ex_memWrite(ex_memWrite), .ex_ALUSrc(ex_ALUSrc), .ex_regWrite(ex_regWrite),
        .ex_setFlags(ex_setFlags), .ex_ALUOp(ex_ALUOp), .ex_rd(ex_rd), .ex_rn(ex_rn),
        .ex_rm(ex_rm), .mem_valid(mem_valid), .mem_memRead(mem_memRead),
        .mem_memWrite(mem_memWrite), .mem_memToReg(mem_memToReg),
        .mem_regWrite(mem_regWrite), .mem_rd(mem_rd), .wb_valid(wb_valid),
        .wb_memToReg(wb_memToReg), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
        .stall_count(stall_count)
    );

    // f[12..0] = immediate, reg2Loc, setPCReg, link, uncondBranch, cbBranch, cbzBranch,
    //            memRead, memToReg, memWrite, ALUSrc, regWrite, setFlags
    typedef struct packed {
        logic        valid;
        logic [12:0] f;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
    } ex_t;

    typedef struct {
        logic [10:0] mask;
        logic [10:0] match;
        logic [12:0] f;
        logic [2:0]  alu;
        bit          use_rn;
        int          src2;      // 0 none, 1 Rm, 2 Rt
    } dec_t;

    typedef struct {
        logic [31:0] ins;
        logic [12:0] f;
        logic [2:0]  alu;
    } vec_t;

    dec_t dtab[10];
    vec_t vt[11];
    ex_t  a_ex, m_ex, m_mem, m_wb;
    logic [9:0] a_mem;
    logic [7:0] a_wb;
    int   m_cnt;
    int   checks = 0;
    int   errors = 0;
    logic st;

    assign a_ex  = {ex_valid, ex_immediate, ex_reg2Loc, ex_setPCReg, ex_link, ex_uncondBranch,
                    ex_cbBranch, ex_cbzBranch, ex_memRead, ex_memToReg, ex_memWrite,
                    ex_ALUSrc, ex_regWrite, ex_setFlags, ex_ALUOp, ex_rd, ex_rn, ex_rm};
    assign a_mem = {mem_valid, mem_memRead, mem_memWrite, mem_memToReg, mem_regWrite, mem_rd};
    assign a_wb  = {wb_valid, wb_memToReg, wb_regWrite, wb_rd};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int find_op(input logic [31:0] ins);
        for (int i = 0; i < 10; i++)
            if ((ins[31:21] & dtab[i].mask) == dtab[i].match) return i;
        return -1;
    endfunction

    function automatic ex_t model_decode(input logic [31:0] ins);
        ex_t e;
        int  k;
        e       = '0;
        e.valid = 1'b1;
        e.rd    = ins[4:0];
        e.rn    = ins[9:5];
        e.rm    = ins[20:16];
        k       = find_op(ins);
        if (k >= 0) begin
            e.f   = dtab[k].f;
            e.alu = dtab[k].alu;
        end
        return e;
    endfunction

    // Expected stall: the load in EX writes a register the ID instruction reads.
    function automatic logic model_stall(input logic [31:0] ins, input logic v,
                                         input logic fl, input logic rs);
        int         k;
        logic       dep;
        logic [4:0] r2;
        k   = find_op(ins);
        dep = 1'b0;
        if (k >= 0) begin
            r2 = (dtab[k].src2 == 1) ? ins[20:16] : ins[4:0];
            if (dtab[k].use_rn && ins[9:5] == m_ex.rd) dep = 1'b1;
            if (dtab[k].src2 != 0 && r2 == m_ex.rd) dep = 1'b1;
        end
        return v && m_ex.valid && m_ex.f[5] && (m_ex.rd != 5'd31) && dep && !fl && !rs;
    endfunction

    task automatic cycle(input logic [31:0] ins, input logic v, input logic fl,
                         input logic rs, output logic st_o);
        logic es;
        ex_t  ne;
        id_instr = ins;
        id_valid = v;
        flush    = fl;
        reset    = rs;
        #1;
        es   = model_stall(ins, v, fl, rs);
        st_o = stall;
        chk("stall", {63'd0, stall}, {63'd0, es});
        @(posedge clk);
        if (rs) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
        end else begin
            ne    = (fl || es || !v) ? '0 : model_decode(ins);
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = ne;
            if (es && m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
        chk("ex_bundle", {32'd0, a_ex}, {32'd0, m_ex});
        chk("mem_bundle", {54'd0, a_mem},
            {54'd0, m_mem.valid, m_mem.f[5], m_mem.f[3], m_mem.f[4], m_mem.f[1], m_mem.rd});
        chk("wb_bundle", {56'd0, a_wb}, {56'd0, m_wb.valid, m_wb.f[4], m_wb.f[1], m_wb.rd});
        chk("stall_count", {60'd0, stall_count}, 64'(m_cnt));
        @(negedge clk);
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
    endfunction

    localparam logic [31:0] LDUR3   = 32'hF8400083;  // LDUR X3,[X4]
    localparam logic [31:0] LDUR8   = 32'hF8400128;  // LDUR X8,[X9]
    localparam logic [31:0] LDUR31  = 32'hF840009F;  // LDUR X31,[X4]
    localparam logic [31:0] ADDS_N3 = 32'hAB060065;  // ADDS X5,X3,X6
    localparam logic [31:0] SUBS_M3 = 32'hEB0300E5;  // SUBS X5,X7,X3
    localparam logic [31:0] ADDS_Z  = 32'hAB0603E5;  // ADDS X5,X31,X6

    initial begin
        dtab[0] = '{11'b11111111110, 11'b10010001000, 13'b1000000000110, 3'd2, 1, 0}; // ADDI
        dtab[1] = '{11'b11111111111, 11'b10101011000, 13'b0000000000011, 3'd2, 1, 1}; // ADDS
        dtab[2] = '{11'b11111111111, 11'b11101011000, 13'b0000000000011, 3'd3, 1, 1}; // SUBS
        dtab[3] = '{11'b11111100000, 11'b00010100000, 13'b0000100000000, 3'd0, 0, 0}; // B
        dtab[4] = '{11'b11111100000, 11'b10010100000, 13'b0001100000010, 3'd0, 0, 0}; // BL
        dtab[5] = '{11'b11111111000, 11'b01010100000, 13'b0000010000000, 3'd0, 0, 0}; // B.cond
        dtab[6] = '{11'b11111111000, 11'b10110100000, 13'b0100001000000, 3'd0, 0, 2}; // CBZ
        dtab[7] = '{11'b11111111111, 11'b11010110000, 13'b0110100000000, 3'd0, 1, 0}; // BR
        dtab[8] = '{11'b11111111111, 11'b11111000010, 13'b0000000110110, 3'd2, 1, 0}; // LDUR
        dtab[9] = '{11'b11111111111, 11'b11111000000, 13'b0100000001100, 3'd2, 1, 2}; // STUR

        vt[0]  = '{32'h91001441, 13'b1000000000110, 3'd2};
        vt[1]  = '{32'hAB030041, 13'b0000000000011, 3'd2};
        vt[2]  = '{32'hEB030041, 13'b0000000000011, 3'd3};
        vt[3]  = '{32'h14000010, 13'b0000100000000, 3'd0};
        vt[4]  = '{32'h94000010, 13'b0001100000010, 3'd0};
        vt[5]  = '{32'h54000041, 13'b0000010000000, 3'd0};
        vt[6]  = '{32'hB4000041, 13'b0100001000000, 3'd0};
        vt[7]  = '{32'hD61F0040, 13'b0110100000000, 3'd0};
        vt[8]  = '{32'hF8400041, 13'b0000000110110, 3'd2};
        vt[9]  = '{32'hF8000041, 13'b0100000001100, 3'd2};
        vt[10] = '{32'h00000041, 13'b0000000000000, 3'd0};

        m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;

        // Reset and ADDI latency
        cycle(32'd0, 1'b0, 1'b0, 1'b1, st);
        chk("reset_all_zero", {19'd0, a_ex, a_mem, a_wb, stall_count}, 64'd0);
        cycle(32'h91001441, 1'b1, 1'b0, 1'b0, st);
        chk("addi_ex", {32'd0, a_ex}, {32'd0, 1'b1, 13'b1000000000110, 3'd2, 5'd1, 5'd2, 5'd0});
        cycle(32'd0, 1'b0, 1'b0, 1'b0, st);
        cycle(32'd0, 1'b0, 1'b0, 1'b0, st);
        chk("addi_wb", {56'd0, a_wb}, {56'd0, 1'b1, 1'b0, 1'b1, 5'd1});

        // Opcode walk against literal expectations
        for (int i = 0; i < 11; i++) begin
            cycle(vt[i].ins, 1'b1, 1'b0, 1'b0, st);
            chk($sformatf("walk%0d", i), {32'd0, a_ex},
                {32'd0, 1'b1, vt[i].f, vt[i].alu, vt[i].ins[4:0], vt[i].ins[9:5], vt[i].ins[20:16]});
            cycle(32'd0, 1'b0, 1'b0, 1'b0, st);
        end

        // Load-use via Rn, then via Rm
        cycle(32'd0, 1'b0, 1'b0, 1'b1, st);
        cycle(LDUR3, 1'b1, 1'b0, 1'b0, st);
        cycle(ADDS_N3, 1'b1, 1'b0, 1'b0, st);
        chk("lu_rn_stall", {63'd0, st}, 64'd1);
        chk("lu_rn_bubble", {63'd0, ex_valid}, 64'd0);
        chk("lu_rn_cnt", {60'd0, stall_count}, 64'd1);
        cycle(ADDS_N3, 1'b1, 1'b0, 1'b0, st);
        chk("lu_rn_release", {63'd0, st}, 64'd0);
        chk("lu_rn_ex", {32'd0, a_ex}, {32'd0, 1'b1, 13'b0000000000011, 3'd2, 5'd5, 5'd3, 5'd6});
        cycle(LDUR3, 1'b1, 1'b0, 1'b0, st);
        cycle(SUBS_M3, 1'b1, 1'b0, 1'b0, st);
        chk("lu_rm_stall", {63'd0, st}, 64'd1);
        cycle(SUBS_M3, 1'b1, 1'b0, 1'b0, st);
        chk("lu_rm_release", {63'd0, st}, 64'd0);
        chk("lu_rm_cnt", {60'd0, stall_count}, 64'd2);

        // Load to XZR
        cycle(LDUR31, 1'b1, 1'b0, 1'b0, st);
        cycle(ADDS_Z, 1'b1, 1'b0, 1'b0, st);
        chk("xzr_no_stall", {63'd0, st}, 64'd0);
        chk("xzr_cnt", {60'd0, stall_count}, 64'd2);

        // Flush beats hazard
        cycle(LDUR3, 1'b1, 1'b0, 1'b0, st);
        cycle(ADDS_N3, 1'b1, 1'b1, 1'b0, st);
        chk("flush_stall", {63'd0, st}, 64'd0);
        chk("flush_bubble", {63'd0, ex_valid}, 64'd0);
        chk("flush_cnt", {60'd0, stall_count}, 64'd2);

        // Producer already in MEM: no stall
        cycle(LDUR3, 1'b1, 1'b0, 1'b0, st);
        cycle(LDUR8, 1'b1, 1'b0, 1'b0, st);
        cycle(ADDS_N3, 1'b1, 1'b0, 1'b0, st);
        chk("b2b_no_stall", {63'd0, st}, 64'd0);

        // Saturation, then reset mid-stall
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            cycle(LDUR3, 1'b1, 1'b0, 1'b0, st);
            cycle(ADDS_N3, 1'b1, 1'b0, 1'b0, st);
        end
        chk("sat_cnt", {60'd0, stall_count}, 64'(CNT_MAX));
        cycle(LDUR3, 1'b1, 1'b0, 1'b0, st);
        cycle(ADDS_N3, 1'b1, 1'b0, 1'b1, st);
        chk("rst_mid_stall", {63'd0, st}, 64'd0);
        chk("rst_mid_zero", {19'd0, a_ex, a_mem, a_wb, stall_count}, 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic [31:0] ins;
            int          k;
            k   = $urandom_range(0, 10);
            ins = $urandom;
            ins[31:21] = (k < 10) ? (dtab[k].match | (11'($urandom) & ~dtab[k].mask)) : ins[31:21];
            ins[20:16] = rreg();
            ins[9:5]   = rreg();
            ins[4:0]   = rreg();
            cycle(ins, ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 49) == 0), st);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
